poop_slot_manager: RTL and testbench

//  Owns the 8 poop object slots that feed the poop drawers and the player/poop collision logic.

---
 rtl/poop_slot_manager.sv | 215 +++++++++++++++++++++
 tb/tb_poop_slot_manager.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poop_slot_manager.sv
// poop_slot_manager
// Owns the 8 poop object slots: round-robin allocation on drop requests,
// per-frame ageing/expiry, and one player/poop hit report per frame.
// Optional feature macro: POOP_HIT_RETIRE_EN -- when defined, the slot
// reported by a hit is cleared at the next startOfFrame.
// Handshake note: dropReq is a fire-and-forget pulse with no ready; it is
// either accepted (spawnPulse follows 2..9 cycles later), refused
// (dropReject pulses the next cycle), or silently ignored while a previous
// request is still being scanned/granted.
module poop_slot_manager #(
  parameter int LIFETIME_FRAMES = 180,
  parameter int DROP_GAP_FRAMES = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       dropReq,
  input  logic       playerDrawingRequest,
  input  logic [7:0] poopsDrawingRequest,
  output logic [7:0] poopsEnable,
  output logic       spawnPulse,
  output logic [2:0] spawnIdx,
  output logic       dropReject,
  output logic       hitPulse,
  output logic [2:0] hitIdx,
  output logic [3:0] activeCount,
  output logic [1:0] dbgState
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_GRANT = 2'd2
  } state_t;

  localparam logic [7:0] LIFE_INIT = 8'(LIFETIME_FRAMES);
  localparam logic [7:0] GAP_INIT  = 8'(DROP_GAP_FRAMES);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_rr_ptr;
  logic [7:0] r_enable;
  logic [7:0] r_life [8];
  logic [7:0] r_cooldown;
  logic [2:0] r_spawn_idx;
  logic       r_reject;
  logic       w_reject_nxt;
  logic       r_hit_pulse;
  logic [2:0] r_hit_idx;
  logic       r_hit_flag;
  logic [3:0] r_active_cnt;
  logic [3:0] w_pop;
  logic [7:0] w_hit_vec;
  logic       w_collide;
  logic [2:0] w_hit_low;
  logic       w_full;
  logic       w_drop_ok;
  logic       w_slot_free;
  logic       w_grant;
`ifdef POOP_HIT_RETIRE_EN
  logic       r_retire_pend;
`endif

  // Full is judged on the live enables so a back-to-back request with no
  // cooldown can never start a scan that finds no free slot.
  assign w_full      = &r_enable;
  assign w_drop_ok   = (r_cooldown == 8'd0) && !w_full;
  assign w_slot_free = !r_enable[r_rr_ptr];
  assign w_grant     = (r_state == S_GRANT);
  assign w_hit_vec   = poopsDrawingRequest & r_enable;
  assign w_collide   = playerDrawingRequest && (w_hit_vec != 8'd0);

  // Next-state and reject decision for the allocation FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_reject_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dropReq) begin
          if (w_drop_ok) w_state_nxt = S_SCAN;
          else           w_reject_nxt = 1'b1;
        end
      end
      S_SCAN:  if (w_slot_free) w_state_nxt = S_GRANT;
      S_GRANT: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register plus the registered reject pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_reject <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_reject <= w_reject_nxt;
    end
  end

  // Round-robin pointer walks during SCAN and moves past the slot on GRANT;
  // spawnIdx is captured on entry to GRANT so it is valid with spawnPulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr    <= 3'd0;
      r_spawn_idx <= 3'd0;
    end else begin
      if (r_state == S_SCAN) begin
        if (w_slot_free) r_spawn_idx <= r_rr_ptr;
        else             r_rr_ptr    <= r_rr_ptr + 3'd1;
      end else if (w_grant) begin
        r_rr_ptr <= r_rr_ptr + 3'd1;
      end
    end
  end

  // Per-slot lifetime: a grant wins over ageing so a fresh poop keeps its
  // full lifetime even when the grant lands on a frame boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enable <= 8'd0;
      for (int i = 0; i < 8; i++) r_life[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w_grant && (r_rr_ptr == 3'(i))) begin
          r_enable[i] <= 1'b1;
          r_life[i]   <= LIFE_INIT;
        end
`ifdef POOP_HIT_RETIRE_EN
        else if (startOfFrame && r_retire_pend && (r_hit_idx == 3'(i))) begin
          r_enable[i] <= 1'b0;
          r_life[i]   <= 8'd0;
        end
`endif
        else if (startOfFrame && r_enable[i]) begin
          r_life[i] <= r_life[i] - 8'd1;
          if (r_life[i] == 8'd1) r_enable[i] <= 1'b0;
        end
      end
    end
  end

  // Drop cooldown: reloaded on grant, counts frames down to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cooldown <= 8'd0;
    end else if (w_grant) begin
      r_cooldown <= GAP_INIT;
    end else if (startOfFrame && (r_cooldown != 8'd0)) begin
      r_cooldown <= r_cooldown - 8'd1;
    end
  end

  // Lowest-index colliding slot among the enabled ones.
  always_comb begin
    w_hit_low = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_hit_vec[i]) w_hit_low = 3'(i);
    end
  end

  // Hit latch: one report per frame; a collision on the frame-start cycle
  // already belongs to the new frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_pulse <= 1'b0;
      r_hit_idx   <= 3'd0;
      r_hit_flag  <= 1'b0;
    end else begin
      r_hit_pulse <= 1'b0;
      if (w_collide && (!r_hit_flag || startOfFrame)) begin
        r_hit_pulse <= 1'b1;
        r_hit_idx   <= w_hit_low;
        r_hit_flag  <= 1'b1;
      end else if (startOfFrame) begin
        r_hit_flag <= 1'b0;
      end
    end
  end

`ifdef POOP_HIT_RETIRE_EN
  // Remembers that the latched hit slot must be cleared at the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retire_pend <= 1'b0;
    end else if (w_collide && (!r_hit_flag || startOfFrame)) begin
      r_retire_pend <= 1'b1;
    end else if (startOfFrame) begin
      r_retire_pend <= 1'b0;
    end
  end
`endif

  // Population count of the enable vector.
  always_comb begin
    w_pop = 4'd0;
    for (int i = 0; i < 8; i++) w_pop = w_pop + {3'd0, r_enable[i]};
  end

  // Registered active count, one cycle behind the enables.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_active_cnt <= 4'd0;
    else       r_active_cnt <= w_pop;
  end

  assign poopsEnable = r_enable;
  assign spawnPulse  = w_grant;
  assign spawnIdx    = r_spawn_idx;
  assign dropReject  = r_reject;
  assign hitPulse    = r_hit_pulse;
  assign hitIdx      = r_hit_idx;
  assign activeCount = r_active_cnt;
  assign dbgState    = r_state;

endmodule

// File: tb/tb_poop_slot_manager.sv
// Bench for poop_slot_manager (LIFETIME_FRAMES=30, DROP_GAP_FRAMES=2,
// 16-cycle frames). Honours POOP_HIT_RETIRE_EN when defined.
module tb_poop_slot_manager;

  localparam int LIFE  = 30;
  localparam int GAP   = 2;
  localparam int FRAME = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       startOfFrame;
  logic       dropReq;
  logic       playerDrawingRequest;
  logic [7:0] poopsDrawingRequest;
  logic [7:0] poopsEnable;
  logic       spawnPulse;
  logic [2:0] spawnIdx;
  logic       dropReject;
  logic       hitPulse;
  logic [2:0] hitIdx;
  logic [3:0] activeCount;
  logic [1:0] dbgState;

  int n_checks = 0;
  int n_fail   = 0;
  int n_spawn  = 0;
  int n_hit    = 0;
  int cyc      = 0;
  logic chk_on = 1'b0;

  poop_slot_manager #(.LIFETIME_FRAMES(LIFE), .DROP_GAP_FRAMES(GAP)) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .dropReq(dropReq),
    .playerDrawingRequest(playerDrawingRequest),
    .poopsDrawingRequest(poopsDrawingRequest),
    .poopsEnable(poopsEnable), .spawnPulse(spawnPulse), .spawnIdx(spawnIdx),
    .dropReject(dropReject), .hitPulse(hitPulse), .hitIdx(hitIdx),
    .activeCount(activeCount), .dbgState(dbgState)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Slots are a life table; an accepted drop is a countdown to the cycle the
  // grant becomes visible, with the target slot chosen up front as the first
  // free slot at or after the round-robin pointer.
  typedef struct packed {
    logic [7:0]      en;
    logic [7:0][7:0] life;
    logic [7:0]      cool;
    logic [2:0]      rr;
    logic            busy;
    logic [3:0]      wait_n;
    logic [2:0]      slot;
    logic            spawn_pulse;
    logic [2:0]      spawn_idx;
    logic            reject;
    logic            hit_pulse;
    logic [2:0]      hit_idx;
    logic            hit_flag;
    logic            ret_pend;
    logic [3:0]      cnt;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t model_step(input mdl_t o, input logic sof, input logic drop,
                                      input logic ply, input logic [7:0] draw);
    mdl_t n;
    logic [7:0] vec;
    logic found;
    int d;
    n = o;
    n.cnt = 4'($countones(o.en));
    for (int i = 0; i < 8; i++) begin
      if (o.spawn_pulse && (o.slot == 3'(i))) begin
        n.en[i] = 1'b1;
        n.life[i] = 8'(LIFE);
      end
`ifdef POOP_HIT_RETIRE_EN
      else if (sof && o.ret_pend && (o.hit_idx == 3'(i))) begin
        n.en[i] = 1'b0;
        n.life[i] = 8'd0;
      end
`endif
      else if (sof && o.en[i]) begin
        n.life[i] = o.life[i] - 8'd1;
        if (n.life[i] == 8'd0) n.en[i] = 1'b0;
      end
    end
    if (o.spawn_pulse) n.cool = 8'(GAP);
    else if (sof && (o.cool != 8'd0)) n.cool = o.cool - 8'd1;
    n.reject = 1'b0;
    if (o.spawn_pulse) begin
      n.busy = 1'b0;
      n.spawn_pulse = 1'b0;
      n.rr = o.slot + 3'd1;
    end else if (o.busy) begin
      n.wait_n = o.wait_n - 4'd1;
      if (n.wait_n == 4'd0) begin
        n.spawn_pulse = 1'b1;
        n.spawn_idx = o.slot;
      end
    end else if (drop) begin
      if ((o.cool == 8'd0) && (o.en != 8'hFF)) begin
        found = 1'b0;
        d = 0;
        for (int k = 0; k < 8; k++) begin
          if (!found && !o.en[3'(o.rr + 3'(k))]) begin
            found = 1'b1;
            d = k;
          end
        end
        n.busy = 1'b1;
        n.slot = 3'(o.rr + 3'(d));
        n.wait_n = 4'(d + 1);
      end else begin
        n.reject = 1'b1;
      end
    end
    vec = draw & o.en;
    n.hit_pulse = 1'b0;
    if (ply && (vec != 8'd0) && (!o.hit_flag || sof)) begin
      n.hit_pulse = 1'b1;
      n.hit_flag = 1'b1;
      n.ret_pend = 1'b1;
      for (int k = 7; k >= 0; k--) if (vec[k]) n.hit_idx = 3'(k);
    end else if (sof) begin
      n.hit_flag = 1'b0;
      n.ret_pend = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= '0;
    else       m <= model_step(m, startOfFrame, dropReq, playerDrawingRequest, poopsDrawingRequest);
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (!reset && chk_on) begin
      check("cyc_poopsEnable", poopsEnable, m.en);
      check("cyc_spawnPulse", {7'd0, spawnPulse}, {7'd0, m.spawn_pulse});
      check("cyc_spawnIdx", {5'd0, spawnIdx}, {5'd0, m.spawn_idx});
      check("cyc_dropReject", {7'd0, dropReject}, {7'd0, m.reject});
      check("cyc_hitPulse", {7'd0, hitPulse}, {7'd0, m.hit_pulse});
      check("cyc_hitIdx", {5'd0, hitIdx}, {5'd0, m.hit_idx});
      check("cyc_activeCount", {4'd0, activeCount}, {4'd0, m.cnt});
      if (spawnPulse) n_spawn++;
      if (hitPulse) n_hit++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic drop, input logic ply, input logic [7:0] draw);
    @(negedge clk);
    startOfFrame = (cyc % FRAME == 0);
    dropReq = drop;
    playerDrawingRequest = ply;
    poopsDrawingRequest = draw;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 8'd0);
  endtask

  task automatic to_frame_start();
    while (cyc % FRAME != 0) cycle(1'b0, 1'b0, 8'd0);
  endtask

  task automatic goto_frame(input int f);
    while (cyc < f * FRAME) cycle(1'b0, 1'b0, 8'd0);
  endtask

  int h0;
  int s0;
  logic [2:0] exp_hit_a;
  logic [2:0] exp_hit_b;
  logic [3:0] exp_cnt_exp;
  logic       exp_rej33;
  logic [2:0] exp_idx33;

  initial begin
`ifdef POOP_HIT_RETIRE_EN
    exp_hit_a = 3'd5; exp_hit_b = 3'd5; exp_cnt_exp = 4'd5;
    exp_rej33 = 1'b0; exp_idx33 = 3'd2;
`else
    exp_hit_a = 3'd2; exp_hit_b = 3'd2; exp_cnt_exp = 4'd7;
    exp_rej33 = 1'b1; exp_idx33 = 3'd0;
`endif
    reset = 1'b1;
    startOfFrame = 1'b0;
    dropReq = 1'b0;
    playerDrawingRequest = 1'b0;
    poopsDrawingRequest = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_poopsEnable", poopsEnable, 8'd0);
    check("rst_activeCount", {4'd0, activeCount}, 8'd0);
    check("rst_spawnIdx", {5'd0, spawnIdx}, 8'd0);
    check("rst_hitIdx", {5'd0, hitIdx}, 8'd0);
    check("rst_pulses", {5'd0, spawnPulse, dropReject, hitPulse}, 8'd0);
    reset = 1'b0;
    chk_on = 1'b1;

    // disabled slots requesting draw never hit
    cycle(1'b0, 1'b1, 8'hFF);
    idle(2);
    check("no_hit_when_disabled", 8'(n_hit), 8'd0);

    // eight spaced drops fill slots 0..7 in order
    for (int k = 0; k < 8; k++) begin
      to_frame_start();
      idle(2);
      cycle(1'b1, 1'b0, 8'd0);
      idle(4);
      check("spawn_idx_order", {5'd0, spawnIdx}, 8'(k));
      check("slot_enabled", {7'd0, poopsEnable[k]}, 8'd1);
      idle(2 * FRAME);
    end
    check("all_full_enable", poopsEnable, 8'hFF);
    check("all_full_count", {4'd0, activeCount}, 8'd8);

    // ninth drop with every slot busy is refused
    to_frame_start();
    idle(2);
    cycle(1'b1, 1'b0, 8'd0);
    idle(1);
    check("full_reject", {7'd0, dropReject}, 8'd1);
    check("full_unchanged", poopsEnable, 8'hFF);

    // overlap on slots 2 and 5, twice in one frame -> one hit, index 2
    idle(2);
    h0 = n_hit;
    cycle(1'b0, 1'b1, 8'h24);
    cycle(1'b0, 1'b0, 8'd0);
    cycle(1'b0, 1'b1, 8'h24);
    idle(2);
    check("one_hit_per_frame", 8'(n_hit - h0), 8'd1);
    check("hit_lowest_idx", {5'd0, hitIdx}, 8'd2);

    // next frame overlaps again -> a new hit
    to_frame_start();
    idle(3);
    h0 = n_hit;
    cycle(1'b0, 1'b1, 8'h24);
    idle(2);
    check("hit_next_frame", 8'(n_hit - h0), 8'd1);
    check("hit_next_idx", {5'd0, hitIdx}, {5'd0, exp_hit_a});

    // collision on the frame-start cycle counts for the new frame
    to_frame_start();
    h0 = n_hit;
    cycle(1'b0, 1'b1, 8'h24);
    idle(2);
    check("hit_on_sof", 8'(n_hit - h0), 8'd1);
    check("hit_on_sof_idx", {5'd0, hitIdx}, {5'd0, exp_hit_b});
`ifdef POOP_HIT_RETIRE_EN
    check("retired_slot2", {7'd0, poopsEnable[2]}, 8'd0);
`endif

    // slot 0 (spawned frame 1) expires on the 30th frame start after spawn
    goto_frame(31);
    check("slot0_before_expiry", {7'd0, poopsEnable[0]}, 8'd1);
    cycle(1'b0, 1'b0, 8'd0);
    idle(2);
    check("slot0_expired", {7'd0, poopsEnable[0]}, 8'd0);
    check("count_after_expiry", {4'd0, activeCount}, {4'd0, exp_cnt_exp});

    // two drops in one frame: first reuses slot 0, second hits cooldown
    idle(2);
    cycle(1'b1, 1'b0, 8'd0);
    idle(4);
    check("reuse_slot0", {5'd0, spawnIdx}, 8'd0);
    cycle(1'b1, 1'b0, 8'd0);
    idle(1);
    check("cooldown_reject", {7'd0, dropReject}, 8'd1);

    // drop scanning from the pointer after slot 0
    goto_frame(33);
    idle(2);
    cycle(1'b1, 1'b0, 8'd0);
    idle(1);
    check("drop33_reject", {7'd0, dropReject}, {7'd0, exp_rej33});
    idle(3);
    check("drop33_idx", {5'd0, spawnIdx}, {5'd0, exp_idx33});

    // reset in the middle of a scan aborts the spawn
    goto_frame(35);
    idle(2);
    s0 = n_spawn;
    cycle(1'b1, 1'b0, 8'd0);
    cycle(1'b0, 1'b0, 8'd0);
    reset = 1'b1;
    idle(2);
    check("rst_mid_scan_enable", poopsEnable, 8'd0);
    reset = 1'b0;
    idle(4);
    check("rst_mid_scan_no_spawn", 8'(n_spawn - s0), 8'd0);
    check("rst_mid_scan_count", {4'd0, activeCount}, 8'd0);
    check("rst_mid_scan_idx", {5'd0, spawnIdx}, 8'd0);

    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
